// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the LEGv8 instruction-fetch stage.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DROP  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] BUBBLE_INSTR = 32'h0;
    localparam int unsigned PC_INCR      = 4;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: reset > flush (bubble) > hold > load.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic         flush_i,
    input  logic [31:0]  instr_i,
    input  logic [N-1:0] pc_i,
    input  logic         valid_i,
    output logic [31:0]  instr_o,
    output logic [N-1:0] pc_o,
    output logic         valid_o
);

    logic [31:0]  instr_q, instr_d;
    logic [N-1:0] pc_q, pc_d;
    logic         valid_q, valid_d;

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (flush_i) begin
            instr_d = BUBBLE_INSTR;
            pc_d    = '0;
            valid_d = 1'b0;
        end else if (load_i) begin
            instr_d = instr_i;
            pc_d    = pc_i;
            valid_d = valid_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= BUBBLE_INSTR;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 fetch stage: PC, imem req/ready handshake, redirect and stall handling.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int           N        = 64,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall_d,
    input  logic         pc_src_m,
    input  logic [N-1:0] branch_target_m,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ready,
    input  logic [31:0]  imem_rdata,
    output logic [31:0]  instr_d,
    output logic [N-1:0] pc_d,
    output logic         valid_d
);

    fetch_state_e state_q, state_d;
    logic [N-1:0] fetch_pc_q, fetch_pc_d;
    logic [N-1:0] req_addr_q, req_addr_d;
    logic [31:0]  hold_instr_q, hold_instr_d;
    logic [N-1:0] pc_inc;

    logic         ifid_load;
    logic         ifid_flush;
    logic [31:0]  ifid_instr;
    logic [N-1:0] ifid_pc;
    logic         ifid_valid;

    assign pc_inc = fetch_pc_q + N'(PC_INCR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH: begin
                if (imem_ready) begin
                    if (!pc_src_m && stall_d) state_d = HOLD;
                end else if (pc_src_m) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_ready) state_d = FETCH;
            end
            HOLD: begin
                if (pc_src_m || !stall_d) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        imem_req  = (state_q != HOLD);
        imem_addr = (state_q == DROP) ? req_addr_q : fetch_pc_q;
    end

    // A flush always wins over a decode stall, so it is independent of state.
    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        req_addr_d   = req_addr_q;
        hold_instr_d = hold_instr_q;
        ifid_load    = !stall_d;
        ifid_flush   = pc_src_m;
        ifid_instr   = BUBBLE_INSTR;
        ifid_pc      = '0;
        ifid_valid   = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (pc_src_m) begin
                    fetch_pc_d = branch_target_m;
                    if (!imem_ready) req_addr_d = fetch_pc_q;
                end else if (imem_ready) begin
                    if (stall_d) begin
                        hold_instr_d = imem_rdata;
                    end else begin
                        fetch_pc_d = pc_inc;
                        ifid_instr = imem_rdata;
                        ifid_pc    = fetch_pc_q;
                        ifid_valid = 1'b1;
                    end
                end
            end
            DROP: begin
                if (pc_src_m) fetch_pc_d = branch_target_m;
            end
            HOLD: begin
                if (pc_src_m) begin
                    fetch_pc_d   = branch_target_m;
                    hold_instr_d = BUBBLE_INSTR;
                end else if (!stall_d) begin
                    fetch_pc_d = pc_inc;
                    ifid_instr = hold_instr_q;
                    ifid_pc    = fetch_pc_q;
                    ifid_valid = 1'b1;
                end
            end
            default: begin
                fetch_pc_d = fetch_pc_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q   <= RESET_PC;
            req_addr_q   <= '0;
            hold_instr_q <= BUBBLE_INSTR;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            req_addr_q   <= req_addr_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    if_id_reg #(
        .N(N)
    ) u_if_id (
        .clk     (clk),
        .reset   (reset),
        .load_i  (ifid_load),
        .flush_i (ifid_flush),
        .instr_i (ifid_instr),
        .pc_i    (ifid_pc),
        .valid_i (ifid_valid),
        .instr_o (instr_d),
        .pc_o    (pc_d),
        .valid_o (valid_d)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios then random traffic.
module tb_fetch_stage;

    localparam logic [63:0] RST_PC = 64'h0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_d = 1'b0;
    logic        pc_src_m = 1'b0;
    logic [63:0] branch_target_m = '0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr_d;
    logic [63:0] pc_d;
    logic        valid_d;

    int tests = 0;
    int fails = 0;
    int delivered = 0;
    int lat_mode = 0;

    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    fetch_stage #(
        .N(64),
        .RESET_PC(RST_PC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall_d         (stall_d),
        .pc_src_m        (pc_src_m),
        .branch_target_m (branch_target_m),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .instr_d         (instr_d),
        .pc_d            (pc_d),
        .valid_d         (valid_d)
    );

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ {a[15:0], a[31:16]} ^ 32'h9E37_79B9;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Expected program order: sequential from the last redirect/reset point.
    task automatic apply(input logic r, input logic s, input logic p,
                         input logic [63:0] t);
        reset           = r;
        stall_d         = s;
        pc_src_m        = p;
        branch_target_m = t;
        if (r) begin
            exp_q.delete();
            exp_q.push_back(RST_PC);
        end else if (p) begin
            exp_q.delete();
            exp_q.push_back(t);
        end
        while (exp_q.size() < 16) exp_q.push_back(exp_q[$] + 64'd4);
    endtask

    // Instruction memory with per-request latency.
    logic        active;
    int          cnt;
    logic [63:0] held_addr;

    initial begin
        imem_ready = 1'b0;
        imem_rdata = '0;
        active     = 1'b0;
        cnt        = 0;
        held_addr  = '0;
        forever begin
            @(posedge clk);
            if (reset || (imem_req && imem_ready)) active = 1'b0;
            @(negedge clk);
            if (imem_req) begin
                if (!active) begin
                    active    = 1'b1;
                    held_addr = imem_addr;
                    if (lat_mode < 0)
                        cnt = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
                    else
                        cnt = lat_mode;
                end else begin
                    chk("addr_stable", imem_addr, held_addr);
                end
                if (cnt == 0) begin
                    imem_ready = 1'b1;
                    imem_rdata = word_of(imem_addr);
                end else begin
                    imem_ready = 1'b0;
                    imem_rdata = $urandom;
                    cnt--;
                end
            end else begin
                imem_ready = 1'b0;
                imem_rdata = $urandom;
            end
        end
    end

    // Monitor: a fresh IF/ID entry appears after any edge without stall.
    initial begin
        logic st;
        logic rs;
        logic [63:0] e;
        forever begin
            @(posedge clk);
            st = stall_d;
            rs = reset;
            #1;
            if (!valid_d) begin
                chk("bubble_instr", {32'h0, instr_d}, 64'h0);
                chk("bubble_pc", pc_d, 64'h0);
            end else if (!rs && !st) begin
                if (exp_q.size() == 0) begin
                    chk("sb_nonempty", 64'h0, 64'h1);
                end else begin
                    e = exp_q.pop_front();
                    chk("pc_d", pc_d, e);
                    chk("instr_d", {32'h0, instr_d}, {32'h0, word_of(e)});
                    delivered++;
                end
            end
        end
    end

    initial begin
        logic [63:0] tgt;
        logic r, s, p;
        int k;
        exp_q.push_back(RST_PC);
        apply(1'b1, 1'b0, 1'b0, 64'h0);
        repeat (3) tick();
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_req", {63'h0, imem_req}, 64'h1);
        chk("rst_valid", {63'h0, valid_d}, 64'h0);
        chk("rst_pc_d", pc_d, 64'h0);
        chk("rst_instr", {32'h0, instr_d}, 64'h0);
        apply(1'b0, 1'b0, 1'b0, 64'h0);
        chk("seq_addr0", imem_addr, 64'h0);
        tick();
        chk("seq_addr1", imem_addr, 64'h4);
        chk("seq_valid1", {63'h0, valid_d}, 64'h1);
        chk("seq_pc1", pc_d, 64'h0);
        tick();
        chk("seq_addr2", imem_addr, 64'h8);
        chk("seq_pc2", pc_d, 64'h4);
        apply(1'b0, 1'b1, 1'b0, 64'h0);
        tick();
        chk("hold_req", {63'h0, imem_req}, 64'h0);
        chk("hold_addr", imem_addr, 64'h8);
        chk("hold_pc_d", pc_d, 64'h4);
        tick();
        tick();
        chk("hold_req3", {63'h0, imem_req}, 64'h0);
        chk("hold_pc_d3", pc_d, 64'h4);
        apply(1'b0, 1'b0, 1'b0, 64'h0);
        tick();
        chk("rel_pc_d", pc_d, 64'h8);
        chk("rel_instr", {32'h0, instr_d}, {32'h0, word_of(64'h8)});
        chk("rel_addr", imem_addr, 64'hC);
        tick();
        chk("rel_pc_d2", pc_d, 64'hC);
        apply(1'b0, 1'b1, 1'b1, 64'h400);
        tick();
        chk("flush_valid", {63'h0, valid_d}, 64'h0);
        chk("flush_addr", imem_addr, 64'h400);
        apply(1'b0, 1'b0, 1'b0, 64'h0);
        tick();
        chk("tgt_addr", imem_addr, 64'h404);
        chk("tgt_pc_d", pc_d, 64'h400);
        apply(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
        tick();
        chk("wrap_a0", imem_addr, 64'hFFFF_FFFF_FFFF_FFF8);
        apply(1'b0, 1'b0, 1'b0, 64'h0);
        tick();
        chk("wrap_a1", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        chk("wrap_a2", imem_addr, 64'h0);
        chk("wrap_pc_d", pc_d, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        chk("wrap_pc_d2", pc_d, 64'h0);
        apply(1'b1, 1'b0, 1'b0, 64'h0);
        #1 lat_mode = 3;
        tick();
        apply(1'b0, 1'b0, 1'b1, 64'h100);
        tick();
        chk("drop_addr1", imem_addr, 64'h0);
        chk("drop_req1", {63'h0, imem_req}, 64'h1);
        chk("drop_valid1", {63'h0, valid_d}, 64'h0);
        apply(1'b0, 1'b0, 1'b0, 64'h0);
        tick();
        chk("drop_addr2", imem_addr, 64'h0);
        tick();
        chk("drop_addr3", imem_addr, 64'h0);
        chk("drop_valid3", {63'h0, valid_d}, 64'h0);
        tick();
        chk("drop_next", imem_addr, 64'h100);
        chk("drop_valid4", {63'h0, valid_d}, 64'h0);
        apply(1'b0, 1'b0, 1'b1, 64'h200);
        tick();
        chk("drop2_addr", imem_addr, 64'h100);
        apply(1'b1, 1'b0, 1'b0, 64'h0);
        tick();
        chk("rdrop_addr", imem_addr, RST_PC);
        chk("rdrop_req", {63'h0, imem_req}, 64'h1);
        chk("rdrop_valid", {63'h0, valid_d}, 64'h0);
        chk("rdrop_pc_d", pc_d, 64'h0);
        apply(1'b0, 1'b0, 1'b0, 64'h0);
        #1 lat_mode = -1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            k   = int'($urandom_range(0, 99));
            r   = (k < 1);
            p   = !r && (k < 9);
            s   = ($urandom_range(0, 3) == 0);
            tgt = {$urandom, $urandom} & ~64'h3;
            if ($urandom_range(0, 7) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0;
            apply(r, s, p, tgt);
        end
        tick();
        apply(1'b0, 1'b0, 1'b0, 64'h0);
        repeat (20) tick();
        chk("progress", {63'h0, delivered > 500}, 64'h1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
